alu_exec_iter: RTL and testbench

Execute-stage ALU that consumes the 4-bit control code produced by ALU_Control and computes the selected operation on two operands. Logic and arithmetic ops finish in one cycle. Shifts use a one-bit-per-cycle serial shifter instead of a barrel shifter, to save area. A start/busy/done handshake lets the multicycle datapath stall while a shift iterates.

---
 rtl/alu_exec_iter.sv | 118 +++++++++++
 tb/tb_alu_exec_iter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/alu_exec_iter.sv
// Execute-stage ALU: single-cycle logic/arithmetic ops, serial one-bit-per-cycle shifter
// for SLL/SRL/SRA, with a start/busy/done handshake for the multicycle datapath.
`timescale 1ns/1ps
module alu_exec_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             done,
  output logic             busy,
  output logic             illegal
);
  localparam int SHAMT_W = $clog2(WIDTH);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1000;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     result_r;
  logic [SHAMT_W-1:0]   cnt;
  logic [3:0]           op_r;
  logic                 illegal_r;
  logic                 accept;
  logic                 is_shift;
  logic [SHAMT_W-1:0]   shamt;

  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v,
                                                 input logic [3:0]       op);
    case (op)
      OP_SLL:  return {v[WIDTH-2:0], 1'b0};
      OP_SRA:  return {v[WIDTH-1], v[WIDTH-1:1]};
      default: return {1'b0, v[WIDTH-1:1]};
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] alu_one_cycle(input logic [WIDTH-1:0] x,
                                                     input logic [WIDTH-1:0] y,
                                                     input logic [3:0]       op);
    logic signed [WIDTH-1:0] xs;
    logic signed [WIDTH-1:0] ys;
    xs = x;
    ys = y;
    case (op)
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_ADD:  return x + y;
      OP_XOR:  return x ^ y;
      OP_SUB:  return x - y;
      OP_SLT:  return {{(WIDTH-1){1'b0}}, (xs < ys)};
      // Zero-amount shifts pass A straight through
      OP_SLL, OP_SRL, OP_SRA: return x;
      default: return '0;
    endcase
  endfunction

  assign shamt    = b[SHAMT_W-1:0];
  assign is_shift = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);
  assign accept   = start && (state != SHIFT);

  assign result  = result_r;
  assign zero    = (result_r == '0);
  assign done    = (state == DONE);
  assign busy    = (state == SHIFT);
  assign illegal = illegal_r;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_nxt = (is_shift && (shamt != '0)) ? SHIFT : DONE;
        else        state_nxt = IDLE;
      end
      SHIFT: begin
        if (cnt == SHAMT_W'(1)) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Accept stage latches operands; the shift stage iterates on result_r
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r  <= '0;
      cnt       <= '0;
      op_r      <= OP_AND;
      illegal_r <= 1'b0;
    end else if (accept) begin
      result_r  <= alu_one_cycle(a, b, alu_ctrl);
      cnt       <= is_shift ? shamt : '0;
      op_r      <= alu_ctrl;
      illegal_r <= (alu_ctrl > OP_SLT);
    end else if (state == SHIFT) begin
      result_r <= shift_one(result_r, op_r);
      cnt      <= cnt - SHAMT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_exec_iter.sv
// Directed self-checking bench for alu_exec_iter with hand-computed expectations.
`timescale 1ns/1ps
module tb_alu_exec_iter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  alu_ctrl = 4'h0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] result;
  logic        zero, done, busy, illegal;

  int checks = 0;
  int failures = 0;

  alu_exec_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_ctrl(alu_ctrl),
    .a(a), .b(b), .result(result), .zero(zero), .done(done),
    .busy(busy), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one op, scramble operands after accept, count busy cycles, check the done cycle
  task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] aa,
                        input logic [31:0] bb, input int exp_busy,
                        input logic [31:0] exp_res, input logic exp_ill);
    int  nb;
    bit  overlap;
    @(negedge clk);
    start = 1'b1; alu_ctrl = c; a = aa; b = bb;
    @(negedge clk);
    start = 1'b0; alu_ctrl = 4'($urandom); a = $urandom; b = $urandom;
    nb = 0;
    overlap = 0;
    while (busy && nb < 100) begin
      if (done) overlap = 1;
      nb++;
      @(negedge clk);
    end
    check_eq({tag, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
    check_eq({tag, "_busy_done_overlap"}, 32'(overlap), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd1);
    check_eq({tag, "_result"}, result, exp_res);
    check_eq({tag, "_zero"}, 32'(zero), 32'(exp_res == 32'd0));
    check_eq({tag, "_illegal"}, 32'(illegal), 32'(exp_ill));
    @(negedge clk);
    check_eq({tag, "_done_drop"}, 32'(done), 32'd0);
    check_eq({tag, "_result_hold"}, result, exp_res);
  endtask

  initial begin
    int ndone, first_done, nbusy;
    logic [31:0] res9, res10;

    #3;
    check_eq("rst_result", result, 32'd0);
    check_eq("rst_zero", 32'(zero), 32'd1);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add",     4'b0010, 32'd5,        32'd7,        0, 32'd12,       1'b0);
    run_op("sub_neg", 4'b0110, 32'd5,        32'd7,        0, 32'hFFFFFFFE, 1'b0);
    run_op("sub_eq",  4'b0110, 32'd9,        32'd9,        0, 32'd0,        1'b0);
    run_op("sra4",    4'b0111, 32'h80000000, 32'd4,        4, 32'hF8000000, 1'b0);
    run_op("srl4",    4'b0101, 32'h80000000, 32'd4,        4, 32'h08000000, 1'b0);
    run_op("sll5",    4'b0100, 32'd1,        32'h25,       5, 32'h00000020, 1'b0);
    run_op("sll0",    4'b0100, 32'h1234,     32'd0,        0, 32'h00001234, 1'b0);
    run_op("slt_t",   4'b1000, 32'hFFFFFFFF, 32'd1,        0, 32'd1,        1'b0);
    run_op("slt_f",   4'b1000, 32'd1,        32'hFFFFFFFF, 0, 32'd0,        1'b0);
    run_op("illegal", 4'b1111, 32'h55,       32'h66,       0, 32'd0,        1'b1);
    run_op("and",     4'b0000, 32'hF0,       32'h3C,       0, 32'h30,       1'b0);
    run_op("or",      4'b0001, 32'hF0,       32'h0F,       0, 32'hFF,       1'b0);
    run_op("xor",     4'b0011, 32'hFF,       32'h0F,       0, 32'hF0,       1'b0);

    // Start ignored during SHIFT, then restart accepted in the done cycle
    @(negedge clk);
    start = 1'b1; alu_ctrl = 4'b0101; a = 32'h80000000; b = 32'd8;
    ndone = 0; first_done = 0; nbusy = 0; res9 = '0; res10 = '0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (first_done == 0) first_done = k;
      end
      if (k == 9) res9 = result;
      if (k == 10) res10 = result;
      start = 1'b0;
      if (k == 2) begin start = 1'b1; alu_ctrl = 4'b0010; a = 32'd100; b = 32'd200; end
      if (k == 9) begin start = 1'b1; alu_ctrl = 4'b0010; a = 32'd3; b = 32'd4; end
    end
    check_eq("b2b_busy_cycles", 32'(nbusy), 32'd8);
    check_eq("b2b_first_done", 32'(first_done), 32'd9);
    check_eq("b2b_done_count", 32'(ndone), 32'd2);
    check_eq("b2b_shift_result", res9, 32'h00800000);
    check_eq("b2b_add_result", res10, 32'd7);

    // Reset in the middle of a long shift
    @(negedge clk);
    start = 1'b1; alu_ctrl = 4'b0100; a = 32'd1; b = 32'd20;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_result", result, 32'd0);
    check_eq("mid_rst_zero", 32'(zero), 32'd1);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_done", 32'(done), 32'd0);
    check_eq("mid_rst_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check_eq("post_rst_quiet", 32'(ndone), 32'd0);
    run_op("add_after_rst", 4'b0010, 32'd1, 32'd1, 0, 32'd2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
